// File: rtl/blake2b_if.sv
// Header-in / digest-out bundle for the BLAKE2b-256 header hasher.
interface blake2b_if;
    logic [639:0] header_half;
    logic [255:0] hash;
    logic         hash_valid;

    modport master (output header_half, input hash, input hash_valid);
    modport slave  (input header_half, output hash, output hash_valid);
endinterface

// File: rtl/blake2b.sv
// Free-running BLAKE2b-256 of an 80-byte header: one LOAD, 24 half-round steps
// (four G lanes each), one FINAL cycle that publishes the digest.
module blake2b (
    input  logic     clk,
    input  logic     rst_n,
    blake2b_if.slave bus
);
    typedef enum logic [1:0] {LOAD, ROUND, FINAL} state_t;

    localparam logic [63:0] IV [0:7] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    // Parameter block: digest length 32, no key, fanout/depth 1.
    localparam logic [63:0] H_PARAM = 64'h0000_0000_0101_0020;
    localparam logic [63:0] MSG_LEN = 64'd80;

    // Each row packs SIGMA entry k into nibble k.
    localparam logic [63:0] SIGMA_ROWS [0:9] = '{
        64'hfedcba9876543210, 64'h357b20c16df984ae,
        64'h491763eadf250c8b, 64'h8f04a562ebcd1397,
        64'hd386cb1efa427509, 64'h91ef57d438b0a6c2,
        64'hb8293670a4def15c, 64'ha2684f05931ce7bd,
        64'h5a417d2c803b9ef6, 64'h0dc3e9bf5167482a
    };

    function automatic logic [3:0] sigma(input logic [3:0] rnd, input int k);
        logic [3:0] row;
        row = (rnd >= 4'd10) ? rnd - 4'd10 : rnd;
        return SIGMA_ROWS[row][4*k +: 4];
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    state_t        state_reg, state_next;
    logic [4:0]    count_reg, count_next;
    logic [639:0]  msg_reg, msg_next;
    logic [63:0]   v_reg [0:15];
    logic [63:0]   v_next [0:15];
    logic [255:0]  hash_reg, hash_next;
    logic          hash_valid_reg, hash_valid_next;

    logic [3:0]    round_idx;
    logic          diag;
    logic [63:0]   lane_a [0:3];
    logic [63:0]   lane_b [0:3];
    logic [63:0]   lane_c [0:3];
    logic [63:0]   lane_d [0:3];
    logic [255:0]  digest;

    assign round_idx = count_reg[4:1];
    assign diag      = count_reg[0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam int CB = 4 + gi;
            localparam int CC = 8 + gi;
            localparam int CD = 12 + gi;
            localparam int DB = 4 + ((gi + 1) % 4);
            localparam int DC = 8 + ((gi + 2) % 4);
            localparam int DD = 12 + ((gi + 3) % 4);

            logic [3:0]  sel_x, sel_y;
            logic [63:0] a0, b0, c0, d0, x, y;
            logic [63:0] a1, b1, c1, d1, a2, b2, c2, d2;

            always_comb begin
                sel_x = sigma(round_idx, 2*gi + (diag ? 8 : 0));
                sel_y = sigma(round_idx, 2*gi + 1 + (diag ? 8 : 0));
                // Words 10..15 are the zero padding and are never stored.
                x  = (sel_x < 4'd10) ? msg_reg[{sel_x, 6'd0} +: 64] : 64'd0;
                y  = (sel_y < 4'd10) ? msg_reg[{sel_y, 6'd0} +: 64] : 64'd0;
                a0 = v_reg[gi];
                b0 = diag ? v_reg[DB] : v_reg[CB];
                c0 = diag ? v_reg[DC] : v_reg[CC];
                d0 = diag ? v_reg[DD] : v_reg[CD];
                a1 = a0 + b0 + x;
                d1 = rotr(d0 ^ a1, 32);
                c1 = c0 + d1;
                b1 = rotr(b0 ^ c1, 24);
                a2 = a1 + b1 + y;
                d2 = rotr(d1 ^ a2, 16);
                c2 = c1 + d2;
                b2 = rotr(b1 ^ c2, 63);
            end

            assign lane_a[gi] = a2;
            assign lane_b[gi] = b2;
            assign lane_c[gi] = c2;
            assign lane_d[gi] = d2;
        end
    endgenerate

    // Digest byte k is little-endian byte k of h'[k/8]; byte 0 lands in the MSB.
    always_comb begin
        logic [63:0] hp;
        digest = '0;
        for (int k = 0; k < 32; k++) begin
            hp = ((k / 8 == 0) ? (IV[0] ^ H_PARAM) : IV[k / 8]) ^ v_reg[k / 8] ^ v_reg[k / 8 + 8];
            digest[255 - 8*k -: 8] = hp[8*(k % 8) +: 8];
        end
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        msg_next        = msg_reg;
        hash_next       = hash_reg;
        hash_valid_next = 1'b0;
        for (int i = 0; i < 16; i++) v_next[i] = v_reg[i];

        case (state_reg)
            LOAD: begin
                msg_next = bus.header_half;
                for (int i = 0; i < 8; i++) begin
                    v_next[i]     = IV[i];
                    v_next[i + 8] = IV[i];
                end
                v_next[0]  = IV[0] ^ H_PARAM;
                v_next[12] = IV[4] ^ MSG_LEN;
                v_next[14] = ~IV[6];
                count_next = 5'd0;
                state_next = ROUND;
            end
            ROUND: begin
                for (int i = 0; i < 4; i++) begin
                    v_next[i] = lane_a[i];
                    if (!diag) begin
                        v_next[4 + i]  = lane_b[i];
                        v_next[8 + i]  = lane_c[i];
                        v_next[12 + i] = lane_d[i];
                    end else begin
                        v_next[4 + ((i + 1) % 4)]  = lane_b[i];
                        v_next[8 + ((i + 2) % 4)]  = lane_c[i];
                        v_next[12 + ((i + 3) % 4)] = lane_d[i];
                    end
                end
                if (count_reg == 5'd23) begin
                    count_next = 5'd0;
                    state_next = FINAL;
                end else begin
                    count_next = count_reg + 5'd1;
                end
            end
            FINAL: begin
                hash_next       = digest;
                hash_valid_next = 1'b1;
                state_next      = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= LOAD;
            count_reg      <= 5'd0;
            msg_reg        <= '0;
            hash_reg       <= '0;
            hash_valid_reg <= 1'b0;
            for (int i = 0; i < 16; i++) v_reg[i] <= 64'd0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            msg_reg        <= msg_next;
            hash_reg       <= hash_next;
            hash_valid_reg <= hash_valid_next;
            for (int i = 0; i < 16; i++) v_reg[i] <= v_next[i];
        end
    end

    assign bus.hash       = hash_reg;
    assign bus.hash_valid = hash_valid_reg;

endmodule

// File: tb/tb_blake2b.sv
// Scoreboard bench for the BLAKE2b-256 header hasher: expected digests queued
// at each LOAD, popped and compared by a monitor on every hash_valid pulse.
module tb_blake2b;
    logic clk;
    logic rst_n;

    blake2b_if bus ();

    blake2b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam bit [63:0] IV [0:7] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam int SIGMA [0:9][0:15] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
    };

    localparam int GI [0:7][0:3] = '{
        '{0, 4,  8, 12}, '{1, 5,  9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
        '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7,  8, 13}, '{3, 4,  9, 14}
    };

    // Published BLAKE2b-256("abc") (3-byte message) anchors the reference model.
    localparam logic [255:0] KAT_ABC3 =
        256'hbddd813c634239723171ef3fee98579b94964e3bb1cb3e427262c8c068d52319;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Single-block unkeyed BLAKE2b-256 of a message of len bytes (len <= 80).
    function automatic logic [255:0] ref_hash(input logic [639:0] msg, input int len);
        logic [63:0]  h [0:7];
        logic [63:0]  v [0:15];
        logic [63:0]  m [0:15];
        logic [63:0]  a, b, c, d, x, y, w;
        logic [255:0] out;
        for (int i = 0; i < 16; i++) m[i] = (i < 10) ? msg[64*i +: 64] : 64'd0;
        for (int i = 0; i < 8; i++) h[i] = IV[i];
        h[0] = h[0] ^ 64'h0101_0020;
        for (int i = 0; i < 8; i++) begin
            v[i]     = h[i];
            v[i + 8] = IV[i];
        end
        v[12] = v[12] ^ 64'(len);
        v[14] = ~v[14];
        for (int r = 0; r < 12; r++) begin
            for (int j = 0; j < 8; j++) begin
                a = v[GI[j][0]]; b = v[GI[j][1]]; c = v[GI[j][2]]; d = v[GI[j][3]];
                x = m[SIGMA[r % 10][2*j]];
                y = m[SIGMA[r % 10][2*j + 1]];
                a = a + b + x; d = rotr(d ^ a, 32); c = c + d; b = rotr(b ^ c, 24);
                a = a + b + y; d = rotr(d ^ a, 16); c = c + d; b = rotr(b ^ c, 63);
                v[GI[j][0]] = a; v[GI[j][1]] = b; v[GI[j][2]] = c; v[GI[j][3]] = d;
            end
        end
        out = '0;
        for (int k = 0; k < 32; k++) begin
            w = h[k / 8] ^ v[k / 8] ^ v[k / 8 + 8];
            out[255 - 8*k -: 8] = w[8*(k % 8) +: 8];
        end
        return out;
    endfunction

    int           n_cmp;
    int           n_bad;
    int           e_cnt;
    int           next_pulse;
    int           job_no;
    logic [255:0] exp_q [$];
    logic [255:0] last_hash;

    task automatic check256(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Edges since reset release; the first LOAD is edge 1, first FINAL edge 26.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) e_cnt <= 0;
        else        e_cnt <= e_cnt + 1;
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check256("reset_hash", bus.hash, 256'd0);
            check_int("reset_valid", int'(bus.hash_valid), 0);
            last_hash  = '0;
            next_pulse = 26;
        end else if (bus.hash_valid) begin
            job_no++;
            check_int("pulse_edge", e_cnt, next_pulse);
            next_pulse = next_pulse + 26;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got hash %h required no pulse", bus.hash);
            end else begin
                check256("digest", bus.hash, exp_q.pop_front());
            end
            $display("job %0d edge %0d hash %h", job_no, e_cnt, bus.hash);
            last_hash = bus.hash;
        end else begin
            check256("hash_stable", bus.hash, last_hash);
        end
    end

    // Called #1 after a FINAL edge (or after release); the next edge is LOAD.
    task automatic do_job(input logic [639:0] hdr);
        bus.header_half = hdr;
        exp_q.push_back(ref_hash(hdr, 80));
        repeat (26) @(posedge clk);
        #1;
    endtask

    function automatic logic [639:0] rand_hdr();
        logic [639:0] r;
        for (int w = 0; w < 20; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    logic [639:0] abc_hdr;
    logic [639:0] hdr_tmp;

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        job_no     = 0;
        next_pulse = 26;
        last_hash  = '0;
        abc_hdr    = 640'h636261;
        rst_n      = 1'b0;
        bus.header_half = '0;

        check256("model_kat", ref_hash(abc_hdr, 3), KAT_ABC3);

        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        do_job(abc_hdr);
        do_job('0);
        do_job({640{1'b1}});
        for (int i = 0; i < 20; i++) do_job(rand_hdr());

        // Header switched during ROUND cycle 10 must not affect the job in flight.
        bus.header_half = abc_hdr;
        exp_q.push_back(ref_hash(abc_hdr, 80));
        repeat (11) @(posedge clk);
        #1 bus.header_half = '0;
        repeat (15) @(posedge clk);
        #1;
        do_job('0);

        hdr_tmp = rand_hdr();
        for (int i = 0; i < 10; i++) do_job(hdr_tmp);

        // Abort a job at ROUND cycle 12; no digest may come out of it.
        hdr_tmp = rand_hdr();
        bus.header_half = hdr_tmp;
        repeat (13) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check256("async_reset_hash", bus.hash, 256'd0);
        check_int("async_reset_valid", int'(bus.hash_valid), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        do_job(hdr_tmp);

        repeat (3) @(posedge clk);
        check_int("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
